// File: rtl/des_perm_pipe.sv
// DES round P-permutation (forward / inverse / bypass) on LANES 32-bit words,
// followed by a DEPTH-stage valid/ready pipeline with full backpressure.
module des_perm_pipe #(
    parameter int unsigned LANES = 1,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned WIDTH = 32 * LANES,
    localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic [OCC_W-1:0] occupancy
);

    // Table entries use MSB-first bit numbering: bit 0 is the word's MSB.
    localparam logic [4:0] P_TAB [32] = '{
        5'd15, 5'd6,  5'd19, 5'd20, 5'd28, 5'd11, 5'd27, 5'd16,
        5'd0,  5'd14, 5'd22, 5'd25, 5'd4,  5'd17, 5'd30, 5'd9,
        5'd1,  5'd7,  5'd23, 5'd13, 5'd31, 5'd26, 5'd2,  5'd8,
        5'd18, 5'd12, 5'd29, 5'd5,  5'd21, 5'd10, 5'd3,  5'd24
    };

    function automatic logic [31:0] perm_word(input logic [31:0] w, input logic inv);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (inv) begin
                r[5'd31 - P_TAB[i]] = w[5'd31 - 5'(i)];
            end else begin
                r[5'd31 - 5'(i)] = w[5'd31 - P_TAB[i]];
            end
        end
        return r;
    endfunction

    logic [WIDTH-1:0] perm_data;
    logic             perm_err;

    always_comb begin
        perm_data = in_data;
        perm_err  = 1'b0;
        unique case (in_mode)
            2'b00: begin
                for (int k = 0; k < int'(LANES); k++) begin
                    perm_data[32*k +: 32] = perm_word(in_data[32*k +: 32], 1'b0);
                end
            end
            2'b01: begin
                for (int k = 0; k < int'(LANES); k++) begin
                    perm_data[32*k +: 32] = perm_word(in_data[32*k +: 32], 1'b1);
                end
            end
            2'b10: perm_err = 1'b0;
            2'b11: perm_err = 1'b1;
        endcase
    end

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] err_q;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] stage_ready;
    logic             bubble;
    logic [OCC_W-1:0] occ_q;
    logic             accept;
    logic             drain;

    // A stage can load when any stage at or after it is empty, or the output drains.
    always_comb begin
        bubble = out_ready;
        for (int s = int'(DEPTH) - 1; s >= 0; s--) begin
            bubble         = bubble | ~valid_q[s];
            stage_ready[s] = bubble;
        end
    end

    assign in_ready  = stage_ready[0];
    assign accept    = in_valid & stage_ready[0];
    assign drain     = valid_q[DEPTH-1] & out_ready;
    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign out_err   = err_q[DEPTH-1] & valid_q[DEPTH-1];
    assign occupancy = occ_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            err_q   <= '0;
            occ_q   <= '0;
            for (int s = 0; s < int'(DEPTH); s++) begin
                data_q[s] <= '0;
            end
        end else begin
            if (stage_ready[0]) begin
                valid_q[0] <= in_valid;
                if (in_valid) begin
                    data_q[0] <= perm_data;
                    err_q[0]  <= perm_err;
                end
            end
            for (int s = 1; s < int'(DEPTH); s++) begin
                if (stage_ready[s]) begin
                    valid_q[s] <= valid_q[s-1];
                    if (valid_q[s-1]) begin
                        data_q[s] <= data_q[s-1];
                        err_q[s]  <= err_q[s-1];
                    end
                end
            end
            if (accept && !drain) begin
                occ_q <= occ_q + OCC_W'(1);
            end else if (!accept && drain) begin
                occ_q <= occ_q - OCC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_des_perm_pipe.sv
// Bench for des_perm_pipe: three instances (D2/L1, D1/L1, D8/L4) checked every cycle
// against a queue-based model, plus directed vectors with literal expectations.
module tb_des_perm_pipe;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]        in_valid, in_ready, out_valid, out_ready, out_err;
    logic [NI-1:0][1:0]   in_mode;
    logic [NI-1:0][127:0] in_data, out_data;
    logic [NI-1:0][3:0]   occupancy;

    int unsigned cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    int P [32] = '{15, 6, 19, 20, 28, 11, 27, 16, 0, 14, 22, 25, 4, 17, 30, 9,
                   1, 7, 23, 13, 31, 26, 2, 8, 18, 12, 29, 5, 21, 10, 3, 24};

    typedef struct {
        logic [127:0] d;
        logic         e;
        int unsigned  stamp;
    } beat_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Spec-level model: lane 0 at the top, bits numbered MSB-first inside a lane.
    function automatic logic [127:0] model(input logic [127:0] din, input logic [1:0] m,
                                           input int lanes);
        logic [127:0] res;
        logic [31:0]  w, o;
        bit           b [32];
        res = '0;
        for (int k = 0; k < lanes; k++) begin
            w = din[32*(lanes-1-k) +: 32];
            for (int j = 0; j < 32; j++) b[j] = w[31-j];
            o = w;
            if (m == 2'b00) begin
                for (int i = 0; i < 32; i++) o[31-i] = b[P[i]];
            end else if (m == 2'b01) begin
                for (int i = 0; i < 32; i++) o[31-P[i]] = b[i];
            end
            res[32*(lanes-1-k) +: 32] = o;
        end
        return res;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int L  = (g == 2) ? 4 : 1;
        localparam int D  = (g == 0) ? 2 : ((g == 1) ? 1 : 8);
        localparam int OW = $clog2(D + 1);

        des_perm_pipe #(.LANES(L), .DEPTH(D)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_mode  (in_mode[g]),
            .in_data  (in_data[g][32*L-1:0]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data (out_data[g][32*L-1:0]),
            .out_err  (out_err[g]),
            .occupancy(occupancy[g][OW-1:0])
        );

        if (L < 4) begin : g_pad_data
            assign out_data[g][127:32*L] = '0;
        end
        if (OW < 4) begin : g_pad_occ
            assign occupancy[g][3:OW] = '0;
        end

        beat_t q [$];

        // Handshakes sampled mid-cycle take effect at the following rising edge.
        always @(negedge clk) begin
            beat_t b;
            logic  exp_v;
            if (!rst_n) begin
                q.delete();
                chk($sformatf("i%0d reset out_valid", g), out_valid[g], 0);
                chk($sformatf("i%0d reset occupancy", g), occupancy[g], 0);
                chk($sformatf("i%0d reset out_data", g), out_data[g], 0);
                chk($sformatf("i%0d reset in_ready", g), in_ready[g], 1);
            end else begin
                chk($sformatf("i%0d occupancy", g), occupancy[g], q.size());
                chk($sformatf("i%0d in_ready", g), in_ready[g],
                    out_ready[g] || (q.size() < D));
                exp_v = (q.size() > 0) && ((cyc - q[0].stamp) >= unsigned'(D - 1));
                chk($sformatf("i%0d out_valid", g), out_valid[g], exp_v);
                if (out_valid[g] && q.size() > 0) begin
                    chk($sformatf("i%0d out_data", g), out_data[g], q[0].d);
                    chk($sformatf("i%0d out_err", g), out_err[g], q[0].e);
                end
                if (out_valid[g] && out_ready[g] && q.size() > 0) void'(q.pop_front());
                if (in_valid[g] && in_ready[g]) begin
                    b.d     = model(in_data[g], in_mode[g], L);
                    b.e     = (in_mode[g] == 2'b11);
                    b.stamp = cyc + 1;
                    q.push_back(b);
                end
            end
        end
    end

    // Present a beat and return 1 time unit after the edge that accepts it.
    task automatic send(input int g, input logic [1:0] m, input logic [127:0] d);
        bit ok;
        ok = 0;
        in_valid[g] = 1'b1;
        in_mode[g]  = m;
        in_data[g]  = d;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready[g]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL send timeout i%0d: got in_ready=0, expected 1 within 200 cycles", g);
        end
        @(posedge clk);
        #1 in_valid[g] = 1'b0;
    endtask

    task automatic one(input int g, input logic [1:0] m, input logic [127:0] din,
                       input logic [127:0] exp, input logic exp_e, input string name,
                       input int depth);
        send(g, m, din);
        if (depth > 1) begin
            repeat (depth - 1) @(posedge clk);
            #1;
        end
        chk({name, " valid"}, out_valid[g], 1);
        chk({name, " data"}, out_data[g], exp);
        chk({name, " err"}, out_err[g], exp_e);
    endtask

    task automatic stress(input int g, input int depth);
        int n;
        int t;
        n = 0;
        t = 0;
        while (n < 10000 && t < 40000) begin
            in_valid[g]  = ($urandom_range(3) != 0);
            in_mode[g]   = 2'($urandom_range(3));
            in_data[g]   = {$urandom, $urandom, $urandom, $urandom};
            out_ready[g] = ($urandom_range(3) != 0);
            @(negedge clk);
            if (in_valid[g] && in_ready[g]) n++;
            @(posedge clk);
            #1 t++;
        end
        chk($sformatf("i%0d stress beats", g), n, 10000);
        in_valid[g]  = 1'b0;
        out_ready[g] = 1'b1;
        repeat (depth + 1) @(posedge clk);
        #1;
        chk($sformatf("i%0d stress drained occ", g), occupancy[g], 0);
        chk($sformatf("i%0d stress drained valid", g), out_valid[g], 0);
    endtask

    initial begin
        logic [31:0] w, r;
        int          cnt;
        in_valid  = '0;
        out_ready = '1;
        in_mode   = '0;
        in_data   = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int g = 0; g < NI; g++) begin
            chk("post-reset in_ready", in_ready[g], 1);
            chk("post-reset out_valid", out_valid[g], 0);
            chk("post-reset occupancy", occupancy[g], 0);
            chk("post-reset out_data", out_data[g], 0);
            chk("post-reset out_err", out_err[g], 0);
        end

        chk("model fwd msb", model(128'h80000000, 2'b00, 1), 128'h00800000);
        chk("model fwd bit1", model(128'h40000000, 2'b00, 1), 128'h00008000);
        chk("model inv", model(128'h00800000, 2'b01, 1), 128'h80000000);
        chk("model roundtrip", model(model(128'h12345678, 2'b00, 1), 2'b01, 1), 128'h12345678);
        chk("model lanes4", model(128'h80000000_00000000_40000000_FFFFFFFF, 2'b00, 4),
            128'h00800000_00000000_00008000_FFFFFFFF);

        one(0, 2'b00, 128'h80000000, 128'h00800000, 1'b0, "fwd msb", 2);
        one(0, 2'b00, 128'h40000000, 128'h00008000, 1'b0, "fwd bit1", 2);
        one(0, 2'b01, 128'h00800000, 128'h80000000, 1'b0, "inv", 2);
        one(0, 2'b10, 128'hDEADBEEF, 128'hDEADBEEF, 1'b0, "bypass", 2);
        one(0, 2'b11, 128'h12345678, 128'h12345678, 1'b1, "reserved", 2);
        one(0, 2'b10, 128'h12345678, 128'h12345678, 1'b0, "err cleared", 2);
        one(1, 2'b00, 128'h80000000, 128'h00800000, 1'b0, "d1 fwd msb", 1);

        w = $urandom;
        send(0, 2'b00, {96'h0, w});
        @(posedge clk);
        #1 r = out_data[0][31:0];
        one(0, 2'b01, {96'h0, r}, {96'h0, w}, 1'b0, "fwd-inv roundtrip", 2);

        // Back-to-back mode changes; the per-cycle model checks each beat.
        send(0, 2'b00, 128'hCAFEF00D);
        send(0, 2'b01, 128'hCAFEF00D);
        send(0, 2'b11, 128'h0F0F0F0F);
        send(0, 2'b10, 128'h0F0F0F0F);
        send(0, 2'b00, 128'hFFFFFFFF);
        repeat (3) @(posedge clk);
        #1;

        one(2, 2'b00, 128'h80000000_00000000_40000000_FFFFFFFF,
            128'h00800000_00000000_00008000_FFFFFFFF, 1'b0, "lanes4 fwd", 8);

        // Backpressure: stall output, fill, then stream the rest.
        out_ready[0] = 1'b0;
        send(0, 2'b00, 128'h00000001);
        send(0, 2'b01, 128'h00000002);
        chk("full in_ready", in_ready[0], 0);
        chk("full occupancy", occupancy[0], 2);
        fork
            begin
                for (int i = 2; i < 6; i++) send(0, 2'(i % 3), 128'(32'h1111_0000 + i));
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready[0] = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("bp drained occupancy", occupancy[0], 0);

        // Full throughput with out_ready held high.
        cnt = 0;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            in_mode[0] = 2'(i % 3);
            in_data[0] = 128'($urandom);
            @(negedge clk);
            if (in_ready[0]) cnt++;
            @(posedge clk);
            #1;
        end
        in_valid[0] = 1'b0;
        chk("throughput accepts", cnt, 50);
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset with two beats in flight.
        out_ready[0] = 1'b0;
        send(0, 2'b00, 128'hAAAA5555);
        send(0, 2'b01, 128'h5555AAAA);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset out_valid", out_valid[0], 0);
        chk("async reset occupancy", occupancy[0], 0);
        chk("async reset out_data", out_data[0], 0);
        chk("async reset in_ready", in_ready[0], 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready[0] = 1'b1;
        one(0, 2'b00, 128'h80000000, 128'h00800000, 1'b0, "post reset beat", 2);
        repeat (3) @(posedge clk);
        #1;

        fork
            stress(1, 1);
            stress(2, 8);
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
